datapath: RTL and testbench

DATAPATH -- requirements
Module: datapath

---
 rtl/datapath_pkg.sv | 21 ++
 rtl/datapath_regfile.sv | 27 ++
 rtl/datapath.sv | 142 ++++++++++++++
 tb/tb_datapath.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// Shared encodings for the datapath: ALU ops, shifter ops, write-back selects.
package datapath_pkg;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_NOT = 2'b11;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL  = 2'b01;
  localparam logic [1:0] SH_LSR  = 2'b10;
  localparam logic [1:0] SH_ASR  = 2'b11;

  localparam logic [3:0] VSEL_C     = 4'b0001;
  localparam logic [3:0] VSEL_PC    = 4'b0010;
  localparam logic [3:0] VSEL_IMM8  = 4'b0100;
  localparam logic [3:0] VSEL_MDATA = 4'b1000;

  localparam int unsigned NREGS = 8;

endpackage

// File: rtl/datapath_regfile.sv
// 8 x 16-bit register file: combinational read, clocked write.
// A read of the register being written sees the old value until the edge.
module regfile
  import datapath_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        write,
  input  logic [2:0]  writenum,
  input  logic [2:0]  readnum,
  input  logic [15:0] data_in,
  output logic [15:0] data_out
);

  logic [15:0] r [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r[i] <= '0;
    end else if (write) begin
      r[writenum] <= data_in;
    end
  end

  assign data_out = r[readnum];

endmodule

// File: rtl/datapath.sv
// Register file, operand regs, shifter, ALU and status flags.
// Define DATAPATH_OVF_FLAG_EN to enable the overflow flag; else V_out is 0.
module datapath
  import datapath_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  readnum,
  input  logic [3:0]  vsel,
  input  logic        loada,
  input  logic        loadb,
  input  logic [1:0]  shift,
  input  logic        asel,
  input  logic        bsel,
  input  logic [1:0]  ALUop,
  input  logic        loadc,
  input  logic        loads,
  input  logic [2:0]  writenum,
  input  logic        write,
  input  logic [15:0] mdata,
  input  logic [15:0] sximm8,
  input  logic [15:0] sximm5,
  input  logic [7:0]  PC,
  output logic        Z_out,
  output logic        V_out,
  output logic        N_out,
  output logic [15:0] datapath_out
);

  logic [15:0] data_in;
  logic [15:0] data_out;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic [15:0] c_q;
  logic [15:0] sout;
  logic [15:0] ain;
  logic [15:0] bin;
  logic [15:0] alu_out;
  logic        z;
  logic        n;
  logic        z_q;
  logic        n_q;

  regfile u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .write    (write),
    .writenum (writenum),
    .readnum  (readnum),
    .data_in  (data_in),
    .data_out (data_out)
  );

  // non-one-hot selects write zero rather than an OR of sources
  always_comb begin
    case (vsel)
      VSEL_C:     data_in = c_q;
      VSEL_PC:    data_in = {8'h00, PC};
      VSEL_IMM8:  data_in = sximm8;
      VSEL_MDATA: data_in = mdata;
      default:    data_in = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      if (loada) a_q <= data_out;
      if (loadb) b_q <= data_out;
    end
  end

  always_comb begin
    unique case (shift)
      SH_NONE: sout = b_q;
      SH_LSL:  sout = {b_q[14:0], 1'b0};
      SH_LSR:  sout = {1'b0, b_q[15:1]};
      SH_ASR:  sout = {b_q[15], b_q[15:1]};
      default: sout = b_q;
    endcase
  end

  assign ain = asel ? 16'h0000 : a_q;
  assign bin = bsel ? sximm5 : sout;

  always_comb begin
    unique case (ALUop)
      ALU_ADD: alu_out = ain + bin;
      ALU_SUB: alu_out = ain - bin;
      ALU_AND: alu_out = ain & bin;
      ALU_NOT: alu_out = ~bin;
      default: alu_out = '0;
    endcase
  end

  assign z = (alu_out == 16'h0000);
  assign n = alu_out[15];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q <= '0;
      z_q <= 1'b0;
      n_q <= 1'b0;
    end else begin
      if (loadc) c_q <= alu_out;
      if (loads) begin
        z_q <= z;
        n_q <= n;
      end
    end
  end

`ifdef DATAPATH_OVF_FLAG_EN
  logic v;
  logic v_q;

  // overflow: result sign differs from A when effective operand signs agree
  always_comb begin
    unique case (ALUop)
      ALU_ADD: v = (ain[15] == bin[15]) && (alu_out[15] != ain[15]);
      ALU_SUB: v = (ain[15] != bin[15]) && (alu_out[15] != ain[15]);
      default: v = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     v_q <= 1'b0;
    else if (loads) v_q <= v;
  end

  assign V_out = v_q;
`else
  assign V_out = 1'b0;
`endif

  assign datapath_out = c_q;
  assign Z_out        = z_q;
  assign N_out        = n_q;

endmodule

// File: tb/tb_datapath.sv
// Self-checking bench for datapath: vector table, scenarios, random vs model.
module tb_datapath;

  logic        clk;
  logic        rst_n;
  logic [2:0]  readnum;
  logic [3:0]  vsel;
  logic        loada;
  logic        loadb;
  logic [1:0]  shift;
  logic        asel;
  logic        bsel;
  logic [1:0]  ALUop;
  logic        loadc;
  logic        loads;
  logic [2:0]  writenum;
  logic        write;
  logic [15:0] mdata;
  logic [15:0] sximm8;
  logic [15:0] sximm5;
  logic [7:0]  PC;
  logic        Z_out;
  logic        V_out;
  logic        N_out;
  logic [15:0] datapath_out;

  datapath dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .readnum      (readnum),
    .vsel         (vsel),
    .loada        (loada),
    .loadb        (loadb),
    .shift        (shift),
    .asel         (asel),
    .bsel         (bsel),
    .ALUop        (ALUop),
    .loadc        (loadc),
    .loads        (loads),
    .writenum     (writenum),
    .write        (write),
    .mdata        (mdata),
    .sximm8       (sximm8),
    .sximm5       (sximm5),
    .PC           (PC),
    .Z_out        (Z_out),
    .V_out        (V_out),
    .N_out        (N_out),
    .datapath_out (datapath_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // reference state
  logic [15:0] m_r [8];
  logic [15:0] m_a;
  logic [15:0] m_b;
  logic [15:0] m_c;
  logic        m_z;
  logic        m_v;
  logic        m_n;

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int sgn(input logic [15:0] x);
    return (int'(x) >= 32768) ? int'(x) - 65536 : int'(x);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_r[i] = '0;
    m_a = '0; m_b = '0; m_c = '0;
    m_z = 1'b0; m_v = 1'b0; m_n = 1'b0;
  endtask

  // next state from pre-edge state and current inputs
  task automatic model_step();
    logic [15:0] din, sh, ain, bin, res, rd;
    int s;
    logic ov;
    case (vsel)
      4'b0001: din = m_c;
      4'b0010: din = {8'h00, PC};
      4'b0100: din = sximm8;
      4'b1000: din = mdata;
      default: din = 16'h0000;
    endcase
    case (shift)
      2'd0: sh = m_b;
      2'd1: sh = 16'((int'(m_b) * 2) % 65536);
      2'd2: sh = 16'(int'(m_b) / 2);
      default: sh = 16'(int'(m_b) / 2 + ((int'(m_b) >= 32768) ? 32768 : 0));
    endcase
    ain = asel ? 16'h0000 : m_a;
    bin = bsel ? sximm5 : sh;
    ov = 1'b0;
    case (ALUop)
      2'd0: begin
        s = sgn(ain) + sgn(bin);
        res = 16'(s);
        ov = (s > 32767) || (s < -32768);
      end
      2'd1: begin
        s = sgn(ain) - sgn(bin);
        res = 16'(s);
        ov = (s > 32767) || (s < -32768);
      end
      2'd2: res = ain & bin;
      default: res = 16'(65535 - int'(bin));
    endcase
`ifndef DATAPATH_OVF_FLAG_EN
    ov = 1'b0;
`endif
    rd = m_r[readnum];
    if (write) m_r[writenum] = din;
    if (loada) m_a = rd;
    if (loadb) m_b = rd;
    if (loadc) m_c = res;
    if (loads) begin
      m_z = (res == 16'h0000);
      m_n = res[15];
      m_v = ov;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("c_model", datapath_out, m_c);
    check("z_model", {15'd0, Z_out}, {15'd0, m_z});
    check("n_model", {15'd0, N_out}, {15'd0, m_n});
    check("v_model", {15'd0, V_out}, {15'd0, m_v});
  endtask

  task automatic clr();
    readnum = 0; vsel = 0; loada = 0; loadb = 0; shift = 0;
    asel = 0; bsel = 0; ALUop = 0; loadc = 0; loads = 0;
    writenum = 0; write = 0; mdata = 0; sximm8 = 0; sximm5 = 0; PC = 0;
  endtask

  task automatic put_reg(input logic [2:0] idx, input logic [15:0] val);
    clr();
    vsel = 4'b0100; sximm8 = val; writenum = idx; write = 1;
    tick();
    clr();
  endtask

  task automatic readback(input string name, input logic [2:0] idx,
                          input logic [15:0] exp);
    clr();
    readnum = idx; loada = 1;
    tick();
    clr();
    bsel = 1; sximm5 = 0; ALUop = 2'b00; loadc = 1;
    tick();
    check(name, datapath_out, exp);
    clr();
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  sh;
    logic        as;
    logic        bs;
    logic [1:0]  op;
    logic [15:0] imm5;
    logic [15:0] c;
    logic        z;
    logic        n;
    logic        v;
  } vec_t;

  vec_t vt [9];

  initial begin
    logic ve;
    vt[0] = '{16'h0005, 16'h0005, 2'd0, 1'b0, 1'b0, 2'd1, 16'h0, 16'h0000, 1, 0, 0};
    vt[1] = '{16'h7FFF, 16'h0001, 2'd0, 1'b0, 1'b0, 2'd0, 16'h0, 16'h8000, 0, 1, 1};
    vt[2] = '{16'h1234, 16'h8002, 2'd2, 1'b1, 1'b0, 2'd0, 16'h0, 16'h4001, 0, 0, 0};
    vt[3] = '{16'h1234, 16'h8002, 2'd3, 1'b1, 1'b0, 2'd0, 16'h0, 16'hC001, 0, 1, 0};
    vt[4] = '{16'h1234, 16'h5555, 2'd0, 1'b0, 1'b1, 2'd3, 16'h000F, 16'hFFF0, 0, 1, 0};
    vt[5] = '{16'h00F0, 16'h0FF0, 2'd0, 1'b0, 1'b0, 2'd2, 16'h0, 16'h00F0, 0, 0, 0};
    vt[6] = '{16'h8000, 16'h0001, 2'd0, 1'b0, 1'b0, 2'd1, 16'h0, 16'h7FFF, 0, 0, 1};
    vt[7] = '{16'h0003, 16'h0002, 2'd1, 1'b0, 1'b0, 2'd0, 16'h0, 16'h0007, 0, 0, 0};
    vt[8] = '{16'hFFFF, 16'h0001, 2'd0, 1'b0, 1'b0, 2'd0, 16'h0, 16'h0000, 1, 0, 0};

    clr();
    rst_n = 1'b0;
    model_reset();
    #12;
    check("reset_c", datapath_out, 16'h0000);
    check("reset_flags", {13'd0, Z_out, V_out, N_out}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // vector table
    foreach (vt[i]) begin
      put_reg(3'd3, vt[i].a);
      put_reg(3'd4, vt[i].b);
      readnum = 3'd3; loada = 1;
      tick();
      clr();
      readnum = 3'd4; loadb = 1;
      tick();
      clr();
      shift = vt[i].sh; asel = vt[i].as; bsel = vt[i].bs;
      ALUop = vt[i].op; sximm5 = vt[i].imm5; loadc = 1; loads = 1;
      tick();
`ifdef DATAPATH_OVF_FLAG_EN
      ve = vt[i].v;
`else
      ve = 1'b0;
`endif
      check($sformatf("vec%0d_c", i), datapath_out, vt[i].c);
      check($sformatf("vec%0d_z", i), {15'd0, Z_out}, {15'd0, vt[i].z});
      check($sformatf("vec%0d_n", i), {15'd0, N_out}, {15'd0, vt[i].n});
      check($sformatf("vec%0d_v", i), {15'd0, V_out}, {15'd0, ve});
      clr();
    end

    // R0 <- 7, B <- R0, then B observed through C
    put_reg(3'd0, 16'd7);
    readnum = 3'd0; loadb = 1;
    tick();
    clr();
    asel = 1; loadc = 1;
    tick();
    check("s29_b", datapath_out, 16'd7);
    clr();
    // R1 <- 2, A <- R1, C = A + (B<<1) = 16
    put_reg(3'd1, 16'd2);
    readnum = 3'd1; loada = 1;
    tick();
    clr();
    shift = 2'b01; loadc = 1; loads = 1;
    tick();
    check("s30_c", datapath_out, 16'd16);
    check("s30_flags", {13'd0, Z_out, V_out, N_out}, 16'h0000);
    clr();
    vsel = 4'b0001; writenum = 3'd2; write = 1;
    tick();
    clr();
    readback("s29_r0", 3'd0, 16'd7);
    readback("s31_r2", 3'd2, 16'd16);

    // non-one-hot write-back writes zero; PC zero-extended
    put_reg(3'd5, 16'hAAAA);
    vsel = 4'b0011; writenum = 3'd5; write = 1; PC = 8'hFF;
    tick();
    clr();
    readback("vsel_bad", 3'd5, 16'h0000);
    vsel = 4'b0010; writenum = 3'd6; write = 1; PC = 8'hA5;
    tick();
    clr();
    readback("vsel_pc", 3'd6, 16'h00A5);

    // randomized against the model
    for (int k = 0; k < 400; k++) begin
      readnum  = 3'($urandom);
      vsel     = ($urandom_range(0, 3) == 0) ? 4'($urandom) :
                 4'(1 << $urandom_range(0, 3));
      loada    = 1'($urandom);
      loadb    = 1'($urandom);
      shift    = 2'($urandom);
      asel     = ($urandom_range(0, 3) == 0);
      bsel     = ($urandom_range(0, 3) == 0);
      ALUop    = 2'($urandom);
      loadc    = 1'($urandom);
      loads    = 1'($urandom);
      writenum = 3'($urandom);
      write    = 1'($urandom);
      mdata    = 16'($urandom);
      sximm8   = ($urandom_range(0, 1) == 0) ? 16'h7FFF : 16'($urandom);
      sximm5   = 16'($urandom);
      PC       = 8'($urandom);
      tick();
    end
    clr();

    // mid-sequence async reset
    put_reg(3'd7, 16'h1357);
    sximm5 = 16'h8001; bsel = 1; asel = 1; loadc = 1; loads = 1;
    tick();
    clr();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_mid_c", datapath_out, 16'h0000);
    check("rst_mid_flags", {13'd0, Z_out, V_out, N_out}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) readback($sformatf("rst_r%0d", i), 3'(i), 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
